uart_rfifo_ext: RTL and testbench
=================================

Name: uart_rfifo_ext

Overview:
Parametrised receive FIFO for the UART core.
- Stores received characters together with their per-character error flags (parity, framing, break).
- Sits between the receiver shifter and the register-file read path.
- Additions over the previous generation: accurate "error anywhere in FIFO" tracking, a programmable trigger-level flag, flush, a clearable overrun, and full/empty status.

Parameters:
DATA_W, 8, character width in bits.
FLAG_W, 3, per-character error flag bits: bit2 break, bit1 framing, bit0 parity.
DEPTH, 16, number of entries; power of two, minimum 2.
PTR_W, 4, pointer width; equals log2(DEPTH).
CNT_W, 5, counter width; equals PTR_W+1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
push  in  1  write strobe, active high.
pop  in  1  read strobe, active high.
data_in  in  DATA_W+FLAG_W  {character, flags}; character in the upper DATA_W bits.
flush  in  1  synchronous clear of contents and error tracking.
clr_overrun  in  1  synchronous clear of the overrun flag.
trig_level  in  CNT_W  threshold for trig_hit; 0 disables trig_hit.
data_out  out  DATA_W+FLAG_W  head entry, same packing as data_in.
count  out  CNT_W  number of stored entries.
empty  out  1  count==0.
full  out  1  count==DEPTH.
trig_hit  out  1  trig_level!=0 and count>=trig_level.
error_in_fifo  out  1  at least one stored entry has a nonzero flag field.
overrun  out  1  sticky: a push was dropped.

Behaviour:
- Reset (async, rst_n=0):
  - top, bottom, count, err_cnt and overrun go to 0.
  - Outputs read empty=1, full=0, trig_hit=0, error_in_fifo=0.
  - Storage is not cleared; data_out is don't-care while empty.
  - Reset asserted mid-transfer discards the transfer; the first edge after deassertion operates normally.
- All other state updates on the rising clk edge.
- Priority order: flush, then push/pop.
  - flush=1: top=bottom=count=err_cnt=0; push and pop in the same cycle are ignored.
  - flush does not touch overrun.
- push only:
  - Not full: write data_in at top; top+1 (wraps modulo DEPTH); count+1.
  - Full: data dropped, state unchanged, overrun<=1.
- pop only:
  - Not empty: bottom+1 (wraps); count-1.
  - Empty: ignored; no error flag.
- push and pop together:
  - Not empty (including full): write at top, advance both pointers, count unchanged, no overrun.
  - Empty: treat as push only; count becomes 1 and data_out shows the new entry next cycle.
- err_cnt (CNT_W bits):
  - +1 on each accepted push whose flag field is nonzero.
  - -1 on each accepted pop whose head flag field is nonzero.
  - Both in one cycle: net 0.
  - error_in_fifo = (err_cnt!=0), so it clears exactly when the last errored entry leaves.
- overrun:
  - Set by a dropped push.
  - Cleared by clr_overrun.
  - Set has priority over clear in the same cycle.
- data_out:
  - Combinational read of entry[bottom] (show-ahead); no read latency.
  - After a pop, the next entry appears on the following cycle.
- Status outputs derive from registered count/err_cnt only; no combinational path from push/pop to status.
- Pointers and count use natural unsigned wrap; count never exceeds DEPTH and never goes below 0.

Decomposition:
- Shared defines file: FLAG bit positions (BRK=2, FE=1, PE=0) and default DEPTH/DATA_W.
- One sub-module, uart_fifo_ram: DEPTH x (DATA_W+FLAG_W) storage with synchronous write at a write address and asynchronous read at a read address.
- All pointer, count, error and status logic stays in uart_rfifo_ext.

Test Plan:
- Push 0xA5 (flags 000), 0x3C (flags 010), 0x11 (flags 000) -> count=3, error_in_fifo=1, data_out=0xA5/000. Two pops -> error_in_fifo=0, data_out=0x11.
- Push 17 characters into an empty DEPTH=16 FIFO -> full=1, count=16, overrun=1, 17th character absent. Pop all 16 -> values in order. clr_overrun -> overrun=0.
- Full FIFO, push=pop=1 with 0x77 -> count stays 16, overrun=0, 0x77 is the 16th read out.
- Empty FIFO, push=pop=1 with 0x42 -> count=1, data_out=0x42. Then pop on an empty FIFO -> count remains 0.
- trig_level=4: 3 pushes -> trig_hit=0; 4th push -> trig_hit=1; set trig_level=0 -> trig_hit=0.
- 5 entries, 2 errored, then flush=1 together with push -> count=0, error_in_fifo=0, push ignored. Assert rst_n=0 mid-push -> all status outputs immediately at reset values.

Source files
------------

// File: rtl/uart_rfifo_ext_pkg.sv
// Shared constants for the UART receive FIFO: flag bit positions and default sizing.
package uart_rfifo_ext_pkg;

  localparam int FLAG_BRK   = 2;
  localparam int FLAG_FE    = 1;
  localparam int FLAG_PE    = 0;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_FLAG_W = 3;

  // True when a character carries any receive error.
  function automatic logic flag_err(input logic [DEF_FLAG_W-1:0] flags);
    return flags[FLAG_BRK] | flags[FLAG_FE] | flags[FLAG_PE];
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Character storage for the receive FIFO: synchronous write, asynchronous show-ahead read.
module uart_fifo_ram
  import uart_rfifo_ext_pkg::*;
#(
  parameter int WIDTH  = DEF_DATA_W + DEF_FLAG_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rfifo_ext.sv
// UART receive FIFO with per-character error flags, error-anywhere tracking,
// trigger level, flush and sticky overrun.
module uart_rfifo_ext
  import uart_rfifo_ext_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FLAG_W = DEF_FLAG_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH),
  parameter int CNT_W  = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W+FLAG_W-1:0] data_in,
  input  logic                     flush,
  input  logic                     clr_overrun,
  input  logic [CNT_W-1:0]         trig_level,
  output logic [DATA_W+FLAG_W-1:0] data_out,
  output logic [CNT_W-1:0]         count,
  output logic                     empty,
  output logic                     full,
  output logic                     trig_hit,
  output logic                     error_in_fifo,
  output logic                     overrun
);

  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] bot_ptr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             ovr_r;

  logic is_empty;
  logic is_full;
  logic wr_en;
  logic rd_en;
  logic ovr_set;
  logic in_err;
  logic head_err;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CNT_W'(DEPTH));

  // A push into a full FIFO is still accepted when a pop frees the head slot.
  assign wr_en   = !flush && push && (!is_full || pop);
  assign rd_en   = !flush && pop && !is_empty;
  assign ovr_set = !flush && push && !pop && is_full;

  assign in_err   = flag_err(data_in[FLAG_W-1:0]);
  assign head_err = flag_err(data_out[FLAG_W-1:0]);

  uart_fifo_ram #(
    .WIDTH  (DATA_W + FLAG_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (top_ptr),
    .wr_data (data_in),
    .rd_addr (bot_ptr),
    .rd_data (data_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ptr <= '0;
      bot_ptr <= '0;
      cnt     <= '0;
      err_cnt <= '0;
    end else if (flush) begin
      top_ptr <= '0;
      bot_ptr <= '0;
      cnt     <= '0;
      err_cnt <= '0;
    end else begin
      if (wr_en) top_ptr <= top_ptr + PTR_W'(1);
      if (rd_en) bot_ptr <= bot_ptr + PTR_W'(1);
      cnt     <= cnt + CNT_W'(wr_en) - CNT_W'(rd_en);
      err_cnt <= err_cnt + CNT_W'(wr_en && in_err) - CNT_W'(rd_en && head_err);
    end
  end

  // Overrun survives flush; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ovr_r <= 1'b0;
    else if (ovr_set)     ovr_r <= 1'b1;
    else if (clr_overrun) ovr_r <= 1'b0;
  end

  assign count         = cnt;
  assign empty         = is_empty;
  assign full          = is_full;
  assign trig_hit      = (trig_level != '0) && (cnt >= trig_level);
  assign error_in_fifo = (err_cnt != '0);
  assign overrun       = ovr_r;

endmodule

// File: tb/tb_uart_rfifo_ext.sv
// Self-checking bench for uart_rfifo_ext against a queue-based reference model.
module tb_uart_rfifo_ext;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic        push;
  logic        pop;
  logic [10:0] data_in;
  logic        flush;
  logic        clr_overrun;
  logic [4:0]  trig_level;
  logic [10:0] data_out;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        trig_hit;
  logic        error_in_fifo;
  logic        overrun;

  int n_cmp = 0;
  int n_bad = 0;

  logic [10:0] mq[$];
  bit          m_ovr;

  uart_rfifo_ext dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .push          (push),
    .pop           (pop),
    .data_in       (data_in),
    .flush         (flush),
    .clr_overrun   (clr_overrun),
    .trig_level    (trig_level),
    .data_out      (data_out),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .trig_hit      (trig_hit),
    .error_in_fifo (error_in_fifo),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit m_err();
    foreach (mq[i]) if (mq[i][2:0] != 3'b000) return 1'b1;
    return 1'b0;
  endfunction

  // One clock of stimulus; the reference queue follows the FIFO rules directly.
  task automatic drive(input bit p, input bit q, input logic [10:0] d,
                       input bit f = 1'b0, input bit c = 1'b0);
    bit set_ovr;
    push = p; pop = q; data_in = d; flush = f; clr_overrun = c;
    @(posedge clk);
    set_ovr = 1'b0;
    if (f) mq.delete();
    else if (p && q && mq.size() > 0) begin
      void'(mq.pop_front());
      mq.push_back(d);
    end else if (p) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else set_ovr = 1'b1;
    end else if (q && mq.size() > 0) void'(mq.pop_front());
    if (set_ovr) m_ovr = 1'b1;
    else if (c)  m_ovr = 1'b0;
    #1;
    push = 0; pop = 0; flush = 0; clr_overrun = 0;
  endtask

  task automatic test_reset();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty act=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full act=%b exp=0", full); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count act=%0d exp=0", count); end
    n_cmp++; if (trig_hit !== 1'b0) begin n_bad++; $display("FAIL reset_trig act=%b exp=0", trig_hit); end
    n_cmp++; if (error_in_fifo !== 1'b0) begin n_bad++; $display("FAIL reset_err act=%b exp=0", error_in_fifo); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_ovr act=%b exp=0", overrun); end
  endtask

  task automatic test_errors();
    drive(1, 0, {8'hA5, 3'b000});
    drive(1, 0, {8'h3C, 3'b010});
    drive(1, 0, {8'h11, 3'b000});
    n_cmp++; if (count !== 5'd3) begin n_bad++; $display("FAIL err_count act=%0d exp=3", count); end
    n_cmp++; if (error_in_fifo !== 1'b1) begin n_bad++; $display("FAIL err_flag_set act=%b exp=1", error_in_fifo); end
    n_cmp++; if (data_out !== {8'hA5, 3'b000}) begin n_bad++; $display("FAIL err_head act=%h exp=%h", data_out, {8'hA5, 3'b000}); end
    drive(0, 1, '0);
    n_cmp++; if (error_in_fifo !== 1'b1) begin n_bad++; $display("FAIL err_flag_mid act=%b exp=1", error_in_fifo); end
    drive(0, 1, '0);
    n_cmp++; if (error_in_fifo !== 1'b0) begin n_bad++; $display("FAIL err_flag_clr act=%b exp=0", error_in_fifo); end
    n_cmp++; if (data_out !== {8'h11, 3'b000}) begin n_bad++; $display("FAIL err_head2 act=%h exp=%h", data_out, {8'h11, 3'b000}); end
    drive(0, 1, '0);
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 17; i++) drive(1, 0, {8'(i + 8'h20), 3'b000});
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL ovr_full act=%b exp=1", full); end
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL ovr_count act=%0d exp=16", count); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set act=%b exp=1", overrun); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (data_out !== {8'(i + 8'h20), 3'b000}) begin
        n_bad++; $display("FAIL ovr_order[%0d] act=%h exp=%h", i, data_out, {8'(i + 8'h20), 3'b000});
      end
      drive(0, 1, '0);
    end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL ovr_drained act=%b exp=1", empty); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky act=%b exp=1", overrun); end
    drive(0, 0, '0, 0, 1);
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear act=%b exp=0", overrun); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) drive(1, 0, {8'(8'h80 + i), 3'b000});
    drive(1, 1, {8'h77, 3'b000});
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL fpp_count act=%0d exp=16", count); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL fpp_ovr act=%b exp=0", overrun); end
    for (int i = 0; i < 16; i++) begin
      logic [10:0] exp;
      exp = (i == 15) ? {8'h77, 3'b000} : {8'(8'h81 + i), 3'b000};
      n_cmp++;
      if (data_out !== exp) begin n_bad++; $display("FAIL fpp_order[%0d] act=%h exp=%h", i, data_out, exp); end
      drive(0, 1, '0);
    end
  endtask

  task automatic test_empty_push_pop();
    drive(1, 1, {8'h42, 3'b100});
    n_cmp++; if (count !== 5'd1) begin n_bad++; $display("FAIL epp_count act=%0d exp=1", count); end
    n_cmp++; if (data_out !== {8'h42, 3'b100}) begin n_bad++; $display("FAIL epp_head act=%h exp=%h", data_out, {8'h42, 3'b100}); end
    n_cmp++; if (error_in_fifo !== 1'b1) begin n_bad++; $display("FAIL epp_err act=%b exp=1", error_in_fifo); end
    drive(0, 1, '0);
    drive(0, 1, '0);
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL epp_underflow act=%0d exp=0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL epp_empty act=%b exp=1", empty); end
    n_cmp++; if (error_in_fifo !== 1'b0) begin n_bad++; $display("FAIL epp_err_clr act=%b exp=0", error_in_fifo); end
  endtask

  task automatic test_trigger();
    trig_level = 5'd4;
    for (int i = 0; i < 3; i++) drive(1, 0, {8'(i), 3'b000});
    n_cmp++; if (trig_hit !== 1'b0) begin n_bad++; $display("FAIL trig_below act=%b exp=0", trig_hit); end
    drive(1, 0, {8'h03, 3'b000});
    n_cmp++; if (trig_hit !== 1'b1) begin n_bad++; $display("FAIL trig_at act=%b exp=1", trig_hit); end
    trig_level = 5'd0;
    #1;
    n_cmp++; if (trig_hit !== 1'b0) begin n_bad++; $display("FAIL trig_disabled act=%b exp=0", trig_hit); end
    drive(0, 0, '0, 1);
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) drive(1, 0, {8'(8'h50 + i), (i == 1 || i == 3) ? 3'b001 : 3'b000});
    n_cmp++; if (count !== 5'd5) begin n_bad++; $display("FAIL fl_count_pre act=%0d exp=5", count); end
    n_cmp++; if (error_in_fifo !== 1'b1) begin n_bad++; $display("FAIL fl_err_pre act=%b exp=1", error_in_fifo); end
    drive(1, 0, {8'h99, 3'b010}, 1);
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL fl_count act=%0d exp=0", count); end
    n_cmp++; if (error_in_fifo !== 1'b0) begin n_bad++; $display("FAIL fl_err act=%b exp=0", error_in_fifo); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL fl_empty act=%b exp=1", empty); end
    drive(1, 0, {8'h61, 3'b110});
    drive(1, 0, {8'h62, 3'b000});
    trig_level = 5'd1;
    push = 1; data_in = {8'h63, 3'b000};
    #3 rst_n = 0;
    #1;
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL rst_count act=%0d exp=0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty act=%b exp=1", empty); end
    n_cmp++; if (error_in_fifo !== 1'b0) begin n_bad++; $display("FAIL rst_err act=%b exp=0", error_in_fifo); end
    n_cmp++; if (trig_hit !== 1'b0) begin n_bad++; $display("FAIL rst_trig act=%b exp=0", trig_hit); end
    push = 0; trig_level = 5'd0;
    #2 rst_n = 1;
    mq.delete(); m_ovr = 1'b0;
    @(posedge clk); #1;
    drive(1, 0, {8'h64, 3'b000});
    n_cmp++; if (count !== 5'd1 || data_out !== {8'h64, 3'b000}) begin
      n_bad++; $display("FAIL rst_recover act=%0d/%h exp=1/%h", count, data_out, {8'h64, 3'b000});
    end
  endtask

  task automatic test_random();
    int bias;
    bias = 70;
    for (int n = 0; n < 600; n++) begin
      bit p, q, f, c;
      logic [10:0] d;
      if (n % 60 == 0) bias = (bias == 70) ? 25 : 70;
      if (n % 40 == 0) trig_level = 5'($urandom_range(0, 16));
      p = ($urandom_range(0, 99) < bias);
      q = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 5);
      d[10:3] = 8'($urandom);
      d[2:0]  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      drive(p, q, d, f, c);
      n_cmp++; if (count !== 5'(mq.size())) begin n_bad++; $display("FAIL rnd_count[%0d] act=%0d exp=%0d", n, count, mq.size()); end
      n_cmp++; if (empty !== (mq.size() == 0)) begin n_bad++; $display("FAIL rnd_empty[%0d] act=%b", n, empty); end
      n_cmp++; if (full !== (mq.size() == DEPTH)) begin n_bad++; $display("FAIL rnd_full[%0d] act=%b", n, full); end
      n_cmp++; if (error_in_fifo !== m_err()) begin n_bad++; $display("FAIL rnd_err[%0d] act=%b exp=%b", n, error_in_fifo, m_err()); end
      n_cmp++; if (overrun !== m_ovr) begin n_bad++; $display("FAIL rnd_ovr[%0d] act=%b exp=%b", n, overrun, m_ovr); end
      n_cmp++; if (trig_hit !== (trig_level != 0 && mq.size() >= trig_level)) begin
        n_bad++; $display("FAIL rnd_trig[%0d] act=%b lvl=%0d size=%0d", n, trig_hit, trig_level, mq.size());
      end
      if (mq.size() > 0) begin
        n_cmp++; if (data_out !== mq[0]) begin n_bad++; $display("FAIL rnd_head[%0d] act=%h exp=%h", n, data_out, mq[0]); end
      end
    end
  endtask

  initial begin
    rst_n = 0; push = 0; pop = 0; data_in = '0; flush = 0; clr_overrun = 0; trig_level = '0;
    m_ovr = 1'b0;
    #12;
    test_reset();
    #1 rst_n = 1;
    @(posedge clk); #1;
    test_errors();
    test_overrun();
    test_full_push_pop();
    test_empty_push_pop();
    test_trigger();
    test_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
